// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, default
// frame timing and the idle level of the serial line.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int   UART_CLKS_PER_BIT = 87;
    localparam int   UART_DATA_BITS    = 8;
    localparam logic UART_IDLE_LEVEL   = 1'b1;

endpackage : uart_pkg

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous level; both flops come out of
// reset at the idle line level so no false edge is seen after reset.
module uart_sync2
    import uart_pkg::*;
(
    input  logic clk,
    input  logic Reset,
    input  logic d,
    output logic q
);

    logic sync_p0;
    logic sync_p1;

    // Stage 0 catches the metastable sample, stage 1 presents a settled level.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            sync_p0 <= UART_IDLE_LEVEL;
            sync_p1 <= UART_IDLE_LEVEL;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;

endmodule : uart_sync2

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first. Detects the start edge on the synchronized
// line, re-checks it mid-bit, samples each data bit at its centre and
// checks the stop bit before publishing the byte.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 Rx_Serial,
    output logic [DATA_BITS-1:0] Rx_Parallel,
    output logic                 Rx_Valid,
    output logic                 Rx_Frame_Error,
    output logic                 Rx_Busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    // Last count of a full bit period and of the first half of the start bit.
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       LAST_IDX = 3'd7;

    uart_state_e          state;
    uart_state_e          next_state;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;

    logic rx_s;
    logic rx_q;
    logic start_edge;

    logic cnt_clr;
    logic shift_en;
    logic valid_set;
    logic err_set;

    uart_sync2 u_sync (
        .clk   (clk),
        .Reset (Reset),
        .d     (Rx_Serial),
        .q     (rx_s)
    );

    // One-cycle delayed copy of the synchronized line for edge detection.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            rx_q <= UART_IDLE_LEVEL;
        end else begin
            rx_q <= rx_s;
        end
    end

    // A falling edge only; a line that stays low never looks like a new start.
    assign start_edge = (rx_q == UART_IDLE_LEVEL) && (rx_s != UART_IDLE_LEVEL);

    // State register, bit-period counter and data index.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            state <= next_state;
            if (cnt_clr) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            // Index wraps 7 -> 0 on the same sample that moves DATA -> STOP.
            if (shift_en) begin
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    // Next-state decode; the counter clears whenever a state ends.
    always_comb begin
        next_state = state;
        cnt_clr    = 1'b0;
        shift_en   = 1'b0;
        valid_set  = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (start_edge) begin
                    next_state = START;
                end
            end
            START: begin
                if (cnt == HALF_END) begin
                    cnt_clr = 1'b1;
                    // Still low at mid start bit: a real frame, otherwise a glitch.
                    if (rx_s != UART_IDLE_LEVEL) begin
                        next_state = DATA;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt == BIT_END) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == LAST_IDX) begin
                        next_state = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt == BIT_END) begin
                    cnt_clr    = 1'b1;
                    next_state = IDLE;
                    if (rx_s == UART_IDLE_LEVEL) begin
                        valid_set = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            default: begin
                cnt_clr    = 1'b1;
                next_state = IDLE;
            end
        endcase
    end

    // Shift register fills LSB first; result and status pulses are registered.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            shreg          <= '0;
            Rx_Parallel    <= '0;
            Rx_Valid       <= 1'b0;
            Rx_Frame_Error <= 1'b0;
        end else begin
            if (shift_en) begin
                shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            end
            if (valid_set) begin
                Rx_Parallel <= shreg;
            end
            Rx_Valid       <= valid_set;
            Rx_Frame_Error <= err_set;
        end
    end

    assign Rx_Busy = (state != IDLE);

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames driven onto Rx_Serial, expected pulses
// queued at stimulus time and matched by an independent output monitor.
module tb_uart_rx;

    localparam int CPB = 87;

    logic       clk = 1'b0;
    logic       Reset;
    logic       Rx_Serial;
    logic [7:0] Rx_Parallel;
    logic       Rx_Valid;
    logic       Rx_Frame_Error;
    logic       Rx_Busy;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         t0;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] last_good = 8'h00;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8)
    ) dut (
        .clk            (clk),
        .Reset          (Reset),
        .Rx_Serial      (Rx_Serial),
        .Rx_Parallel    (Rx_Parallel),
        .Rx_Valid       (Rx_Valid),
        .Rx_Frame_Error (Rx_Frame_Error),
        .Rx_Busy        (Rx_Busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every cycle with a pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (Rx_Valid === 1'b1 || Rx_Frame_Error === 1'b1) begin
            if (Rx_Valid === 1'b1 && Rx_Frame_Error === 1'b1) begin
                n_vec++;
                n_bad++;
                $display("FAIL both_pulses: Rx_Valid and Rx_Frame_Error high together at cycle %0d", cyc);
            end else if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_pulse: valid=%0b err=%0b data=%0h at cycle %0d, expected none",
                         Rx_Valid, Rx_Frame_Error, Rx_Parallel, cyc);
            end else begin
                exp_t e;
                int   lat;
                e   = exp_q.pop_front();
                lat = cyc - e.t0;
                check("pulse_kind_err", {31'd0, Rx_Frame_Error}, {31'd0, e.is_err});
                check("rx_parallel", {24'd0, Rx_Parallel}, {24'd0, e.data});
                n_vec++;
                if (lat < 828 || lat > 831) begin
                    n_bad++;
                    $display("FAIL latency: got %0d cycles, expected 828..831", lat);
                end
            end
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic stop_lvl);
        exp_t e;
        e.is_err = !stop_lvl;
        e.data   = stop_lvl ? d : last_good;
        e.t0     = cyc;
        exp_q.push_back(e);
        if (stop_lvl) last_good = d;
        Rx_Serial = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            Rx_Serial = d[i];
            repeat (CPB) @(negedge clk);
        end
        Rx_Serial = stop_lvl;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s: %0d expected pulses missing, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset     = 1'b1;
        Rx_Serial = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_parallel", {24'd0, Rx_Parallel}, 32'h00);
        check("rst_valid", {31'd0, Rx_Valid}, 32'h0);
        check("rst_ferr", {31'd0, Rx_Frame_Error}, 32'h0);
        check("rst_busy", {31'd0, Rx_Busy}, 32'h0);
        Reset = 1'b0;
        repeat (5) @(negedge clk);

        // Single frame AA as a transmitter would send it.
        send_frame(8'hAA, 1'b1);
        wait_drain("frame_aa");
        repeat (20) @(negedge clk);

        // Back-to-back 00 then FF, one stop bit each.
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_drain("frames_00_ff");
        repeat (20) @(negedge clk);

        // 10-cycle low glitch: busy briefly, then back to idle with nothing out.
        Rx_Serial = 1'b0;
        repeat (6) @(negedge clk);
        check("glitch_busy", {31'd0, Rx_Busy}, 32'h1);
        repeat (4) @(negedge clk);
        Rx_Serial = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_idle", {31'd0, Rx_Busy}, 32'h0);
        check("glitch_hold", {24'd0, Rx_Parallel}, 32'hFF);

        // 55 with a low stop bit, then line held low for three frame times.
        send_frame(8'h55, 1'b0);
        repeat (30 * CPB) @(negedge clk);
        wait_drain("frame_err_55");
        check("low_line_idle", {31'd0, Rx_Busy}, 32'h0);
        check("err_hold", {24'd0, Rx_Parallel}, 32'hFF);
        Rx_Serial = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send_frame(8'h5A, 1'b1);
        wait_drain("frame_5a");
        repeat (20) @(negedge clk);

        // Reset in the middle of data bit 4 of 3C.
        Rx_Serial = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            Rx_Serial = (8'h3C >> i) & 8'h01;
            repeat (CPB) @(negedge clk);
        end
        Rx_Serial = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        check("mid_busy", {31'd0, Rx_Busy}, 32'h1);
        #1 Reset = 1'b1;
        #1;
        check("mid_rst_parallel", {24'd0, Rx_Parallel}, 32'h00);
        check("mid_rst_valid", {31'd0, Rx_Valid}, 32'h0);
        check("mid_rst_ferr", {31'd0, Rx_Frame_Error}, 32'h0);
        check("mid_rst_busy", {31'd0, Rx_Busy}, 32'h0);
        last_good = 8'h00;
        repeat (3) @(negedge clk);
        Reset = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        send_frame(8'hC3, 1'b1);
        wait_drain("frame_c3");
        repeat (20) @(negedge clk);

        // Single-bit patterns at both ends of the byte.
        send_frame(8'h01, 1'b1);
        send_frame(8'h80, 1'b1);
        wait_drain("frames_01_80");
        repeat (50) @(negedge clk);
        check("final_parallel", {24'd0, Rx_Parallel}, 32'h80);
        check("final_busy", {31'd0, Rx_Busy}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_uart_rx
